// File: rtl/wordle_pkg.sv
// Shared types and default sizes for the guess scorer.
package wordle_pkg;
  localparam int NUM_DIGITS = 5;
  localparam int DIGIT_W    = 4;
  localparam int TRIES_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXACT   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/guess_match_unit.sv
// Finds the lowest unconsumed secret position (other than skip_idx_i) holding digit_i.
module guess_match_unit #(
  parameter int NUM_DIGITS = wordle_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = wordle_pkg::DIGIT_W,
  parameter int IDX_W      = 3
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret_i,
  input  logic [DIGIT_W-1:0]            digit_i,
  input  logic [NUM_DIGITS-1:0]         consumed_i,
  input  logic [IDX_W-1:0]              skip_idx_i,
  output logic                          found_o,
  output logic [IDX_W-1:0]              match_idx_o
);
  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    found_o     = 1'b0;
    match_idx_o = '0;
    for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
      if (!consumed_i[j] && (IDX_W'(j) != skip_idx_i) &&
          (secret_i[j*DIGIT_W +: DIGIT_W] == digit_i)) begin
        found_o     = 1'b1;
        match_idx_o = IDX_W'(j);
      end
    end
  end
endmodule

// File: rtl/guess_scorer.sv
// Scores one guess against a secret code: exact hits in one cycle, then
// present hits one digit per cycle, with an attempt counter and win/game-over.
module guess_scorer
  import wordle_pkg::*;
#(
  parameter int NUM_DIGITS = wordle_pkg::NUM_DIGITS,
  parameter int DIGIT_W    = wordle_pkg::DIGIT_W,
  parameter int TRIES_W    = wordle_pkg::TRIES_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] secret,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] guess,
  input  logic                          start,
  input  logic                          load_tries,
  input  logic [TRIES_W-1:0]            tries_in,
  output logic [NUM_DIGITS-1:0]         exact,
  output logic [NUM_DIGITS-1:0]         present,
  output logic                          done,
  output logic                          busy,
  output logic                          win,
  output logic [TRIES_W-1:0]            tries_left,
  output logic                          game_over,
  output logic [1:0]                    state_dbg
);
  localparam int IDX_W = $clog2(NUM_DIGITS + 1);
  localparam int CW    = NUM_DIGITS * DIGIT_W;

  // Handshake: start is a one-cycle request taken only in IDLE with a live game;
  // done pulses for exactly one cycle when exact/present are final, and busy
  // is high from the accepted start through the done cycle.

  state_t                state_q, state_d;
  logic [CW-1:0]         secret_q, secret_d, guess_q, guess_d;
  logic [NUM_DIGITS-1:0] exact_q, exact_d, present_q, present_d;
  logic [NUM_DIGITS-1:0] consumed_q, consumed_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TRIES_W-1:0]    tries_q, tries_d;
  logic                  win_q, win_d, over_q, over_d;

  logic [NUM_DIGITS-1:0] exact_vec;
  logic [DIGIT_W-1:0]    cur_digit;
  logic                  cur_exact;
  logic                  m_found;
  logic [IDX_W-1:0]      m_idx;
  logic [TRIES_W-1:0]    tries_dec;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      exact_vec[i] = (secret_q[i*DIGIT_W +: DIGIT_W] == guess_q[i*DIGIT_W +: DIGIT_W]);
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_exact = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = guess_q[i*DIGIT_W +: DIGIT_W];
        cur_exact = exact_q[i];
      end
    end
  end

  guess_match_unit #(
    .NUM_DIGITS (NUM_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .IDX_W      (IDX_W)
  ) u_match (
    .secret_i    (secret_q),
    .digit_i     (cur_digit),
    .consumed_i  (consumed_q),
    .skip_idx_i  (idx_q),
    .found_o     (m_found),
    .match_idx_o (m_idx)
  );

  assign tries_dec = (tries_q == '0) ? '0 : tries_q - TRIES_W'(1);

  always_comb begin
    state_d    = state_q;
    secret_d   = secret_q;
    guess_d    = guess_q;
    exact_d    = exact_q;
    present_d  = present_q;
    consumed_d = consumed_q;
    idx_d      = idx_q;
    tries_d    = tries_q;
    win_d      = win_q;
    over_d     = over_q;
    case (state_q)
      S_IDLE: begin
        if (load_tries) begin
          tries_d = tries_in;
          win_d   = 1'b0;
          over_d  = (tries_in == '0);
        end else if (start && !over_q && (tries_q != '0)) begin
          secret_d   = secret;
          guess_d    = guess;
          exact_d    = '0;
          present_d  = '0;
          consumed_d = '0;
          state_d    = S_EXACT;
        end
      end
      S_EXACT: begin
        exact_d    = exact_vec;
        consumed_d = exact_vec;
        idx_d      = '0;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        // One extra pass with idx == NUM_DIGITS commits the round results.
        if (idx_q == IDX_W'(NUM_DIGITS)) begin
          state_d = S_DONE;
          tries_d = tries_dec;
          win_d   = &exact_q;
          over_d  = (&exact_q) || (tries_dec == '0);
        end else begin
          if (!cur_exact && m_found) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              if (idx_q == IDX_W'(i)) present_d[i] = 1'b1;
              if (m_idx == IDX_W'(i)) consumed_d[i] = 1'b1;
            end
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      secret_q   <= '0;
      guess_q    <= '0;
      exact_q    <= '0;
      present_q  <= '0;
      consumed_q <= '0;
      idx_q      <= '0;
      tries_q    <= '0;
      win_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      secret_q   <= secret_d;
      guess_q    <= guess_d;
      exact_q    <= exact_d;
      present_q  <= present_d;
      consumed_q <= consumed_d;
      idx_q      <= idx_d;
      tries_q    <= tries_d;
      win_q      <= win_d;
      over_q     <= over_d;
    end
  end

  assign exact      = exact_q;
  assign present    = present_q;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign win        = win_q;
  assign tries_left = tries_q;
  assign game_over  = over_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer: scenario tasks with hand-computed expectations.
module tb_guess_scorer;
  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] secret, guess;
  logic        start, load_tries;
  logic [3:0]  tries_in;
  logic [4:0]  exact, present;
  logic        done, busy, win, game_over;
  logic [3:0]  tries_left;
  logic [1:0]  state_dbg;

  int n_pass  = 0;
  int n_total = 0;

  guess_scorer dut (
    .clk        (clk),
    .rst        (rst),
    .secret     (secret),
    .guess      (guess),
    .start      (start),
    .load_tries (load_tries),
    .tries_in   (tries_in),
    .exact      (exact),
    .present    (present),
    .done       (done),
    .busy       (busy),
    .win        (win),
    .tries_left (tries_left),
    .game_over  (game_over),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [19:0] s, input logic [19:0] g);
    @(negedge clk);
    secret = s; guess = g; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load(input logic [3:0] t);
    @(negedge clk);
    tries_in = t; load_tries = 1'b1;
    @(negedge clk);
    load_tries = 1'b0;
  endtask

  // Caller sits in the first cycle after the start edge; that cycle counts as 1.
  task automatic wait_done(input int limit, output int cycles, output bit seen);
    cycles = 1;
    seen   = done;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      seen = done;
    end
  endtask

  task automatic count_dones(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; load_tries = 1'b0; tries_in = '0; secret = '0; guess = '0;
    repeat (3) @(negedge clk);
    n_total++; if (exact !== 5'b0) $display("FAIL reset_exact: got %b exp 00000", exact); else n_pass++;
    n_total++; if (present !== 5'b0) $display("FAIL reset_present: got %b exp 00000", present); else n_pass++;
    n_total++; if ({done, busy, win, game_over} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {done, busy, win, game_over}); else n_pass++;
    n_total++; if (tries_left !== 4'd0) $display("FAIL reset_tries: got %0d exp 0", tries_left); else n_pass++;
    n_total++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d exp 0", state_dbg); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit seen;
    load(4'd3);
    n_total++; if (tries_left !== 4'd3 || game_over !== 1'b0) $display("FAIL basic_load: got tries=%0d over=%b exp 3/0", tries_left, game_over); else n_pass++;
    pulse_start(20'h65432, 20'h67432);
    n_total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b exp 1", busy); else n_pass++;
    // load_tries while busy must not touch the counter
    @(negedge clk); tries_in = 4'd9; load_tries = 1'b1;
    @(negedge clk); load_tries = 1'b0;
    wait_done(40, cyc, seen);
    n_total++; if (!seen) $display("FAIL basic_done: got no done exp done within 40"); else n_pass++;
    n_total++; if (exact !== 5'b10111) $display("FAIL basic_exact: got %b exp 10111", exact); else n_pass++;
    n_total++; if (present !== 5'b00000) $display("FAIL basic_present: got %b exp 00000", present); else n_pass++;
    n_total++; if (tries_left !== 4'd2 || win !== 1'b0) $display("FAIL basic_tries_win: got tries=%0d win=%b exp 2/0", tries_left, win); else n_pass++;
  endtask

  task automatic test_latency();
    int cyc; bit seen;
    pulse_start(20'h65432, 20'h23456);
    n_total++; if (exact !== 5'b0 || present !== 5'b0) $display("FAIL lat_clear: got exact=%b present=%b exp 0/0", exact, present); else n_pass++;
    wait_done(40, cyc, seen);
    n_total++; if (!seen || cyc != 8) $display("FAIL lat_cycles: got seen=%b cycles=%0d exp 8", seen, cyc); else n_pass++;
    n_total++; if (exact !== 5'b00100) $display("FAIL lat_exact: got %b exp 00100", exact); else n_pass++;
    n_total++; if (present !== 5'b11011) $display("FAIL lat_present: got %b exp 11011", present); else n_pass++;
    @(negedge clk);
    n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL lat_one_cycle: got done=%b busy=%b exp 0/0", done, busy); else n_pass++;
    n_total++; if (exact !== 5'b00100 || present !== 5'b11011) $display("FAIL lat_hold: got %b/%b exp 00100/11011", exact, present); else n_pass++;
  endtask

  task automatic test_repeats();
    int cyc; bit seen;
    load(4'd5);
    pulse_start(20'h43211, 20'h91121);
    wait_done(40, cyc, seen);
    n_total++; if (!seen) $display("FAIL rep_done: got no done exp done"); else n_pass++;
    n_total++; if (exact !== 5'b00001) $display("FAIL rep_exact: got %b exp 00001", exact); else n_pass++;
    n_total++; if (present !== 5'b00110) $display("FAIL rep_present: got %b exp 00110", present); else n_pass++;
    n_total++; if (tries_left !== 4'd4) $display("FAIL rep_tries: got %0d exp 4", tries_left); else n_pass++;
  endtask

  task automatic test_win();
    int cyc; bit seen; int dones;
    pulse_start(20'h65432, 20'h65432);
    wait_done(40, cyc, seen);
    n_total++; if (!seen) $display("FAIL win_done: got no done exp done"); else n_pass++;
    n_total++; if (exact !== 5'b11111 || present !== 5'b0) $display("FAIL win_bits: got %b/%b exp 11111/00000", exact, present); else n_pass++;
    n_total++; if (win !== 1'b1 || game_over !== 1'b1 || tries_left !== 4'd3) $display("FAIL win_flags: got win=%b over=%b tries=%0d exp 1/1/3", win, game_over, tries_left); else n_pass++;
    pulse_start(20'h65432, 20'h11111);
    count_dones(15, dones);
    n_total++; if (dones != 0 || tries_left !== 4'd3 || busy !== 1'b0) $display("FAIL win_locked: got dones=%0d tries=%0d busy=%b exp 0/3/0", dones, tries_left, busy); else n_pass++;
  endtask

  task automatic test_single_try();
    int cyc; bit seen; int dones;
    load(4'd1);
    n_total++; if (tries_left !== 4'd1 || win !== 1'b0 || game_over !== 1'b0) $display("FAIL one_load: got tries=%0d win=%b over=%b exp 1/0/0", tries_left, win, game_over); else n_pass++;
    pulse_start(20'h65432, 20'h65431);
    // start with a winning guess while busy must not disturb the latched operands
    pulse_start(20'h00000, 20'h00000);
    wait_done(40, cyc, seen);
    n_total++; if (!seen) $display("FAIL one_done: got no done exp done"); else n_pass++;
    n_total++; if (exact !== 5'b11110 || present !== 5'b0) $display("FAIL one_bits: got %b/%b exp 11110/00000", exact, present); else n_pass++;
    n_total++; if (tries_left !== 4'd0 || game_over !== 1'b1 || win !== 1'b0) $display("FAIL one_over: got tries=%0d over=%b win=%b exp 0/1/0", tries_left, game_over, win); else n_pass++;
    count_dones(20, dones);
    n_total++; if (dones != 0) $display("FAIL one_no_second: got dones=%0d exp 0", dones); else n_pass++;
  endtask

  task automatic test_load_beats_start();
    int dones;
    @(negedge clk);
    tries_in = 4'd2; load_tries = 1'b1; secret = 20'h65432; guess = 20'h65432; start = 1'b1;
    @(negedge clk);
    load_tries = 1'b0; start = 1'b0;
    n_total++; if (busy !== 1'b0 || tries_left !== 4'd2 || game_over !== 1'b0) $display("FAIL ls_state: got busy=%b tries=%0d over=%b exp 0/2/0", busy, tries_left, game_over); else n_pass++;
    count_dones(12, dones);
    n_total++; if (dones != 0) $display("FAIL ls_no_done: got dones=%0d exp 0", dones); else n_pass++;
  endtask

  task automatic test_zero_tries();
    load(4'd0);
    n_total++; if (game_over !== 1'b1 || tries_left !== 4'd0) $display("FAIL zero_over: got over=%b tries=%0d exp 1/0", game_over, tries_left); else n_pass++;
    pulse_start(20'h65432, 20'h65432);
    n_total++; if (busy !== 1'b0) $display("FAIL zero_start: got busy=%b exp 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dones;
    load(4'd3);
    pulse_start(20'h65432, 20'h23456);
    @(negedge clk);
    n_total++; if (state_dbg !== 2'd2) $display("FAIL mid_state: got %0d exp 2", state_dbg); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if ({exact, present} !== 10'b0 || {done, busy, win, game_over} !== 4'b0 || tries_left !== 4'd0)
      $display("FAIL mid_reset: got exact=%b present=%b flags=%b tries=%0d exp all 0", exact, present, {done, busy, win, game_over}, tries_left); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    count_dones(15, dones);
    n_total++; if (dones != 0 || tries_left !== 4'd0) $display("FAIL mid_no_done: got dones=%0d tries=%0d exp 0/0", dones, tries_left); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency();
    test_repeats();
    test_win();
    test_single_try();
    test_load_beats_start();
    test_zero_tries();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
